fifo_encoder: RTL and testbench

- Transmit-side counterpart of the repeat-on-read FIFO decoder.
- Input stream presents every symbol for two consecutive enabled cycles (a first copy, then a repeat). The block collapses each pair into one FIFO entry and checks that the two copies match.
- Entries drain one per cycle when the downstream side does not stall.
- Sits in front of a serializer/link stage; the decoder on the far end re-expands the words to two cycles.

---
 rtl/fifo_codec_pkg.sv | 22 ++
 rtl/fifo_ptr_ctl.sv | 52 +++++
 rtl/fifo_encoder.sv | 89 ++++++++
 tb/tb_fifo_encoder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fifo_codec_pkg.sv
// Shared definitions for the repeat-pair FIFO encoder/decoder.
// Holds default sizes, the symbol type and the pointer full rule.
package fifo_codec_pkg;

  localparam int unsigned DefDw     = 4;
  localparam int unsigned DefLength = 4;
  localparam int unsigned PtrMaxW   = 16;

  typedef logic [DefDw-1:0] sym_t;

  // Full when the index bits match and the wrap bit (bit aw) differs.
  function automatic logic ptr_full(input logic [PtrMaxW-1:0] rd,
                                    input logic [PtrMaxW-1:0] wr,
                                    input int unsigned        aw);
    logic [PtrMaxW-1:0] diff;
    logic [PtrMaxW-1:0] mask;
    diff = rd ^ wr;
    mask = (PtrMaxW'(1) << aw) - PtrMaxW'(1);
    return ((diff & mask) == '0) && (((diff >> aw) & PtrMaxW'(1)) != '0);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctl.sv
// Read/write pointer control with full/empty detection, occupancy and
// the rule that a full FIFO still accepts a write when a read happens.
module fifo_ptr_ctl
  import fifo_codec_pkg::*;
#(
  parameter int unsigned LENGTH = DefLength,
  parameter int unsigned AW     = $clog2(LENGTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_req_i,
  input  logic          stall_i,
  output logic          wr_en_o,
  output logic          rd_en_o,
  output logic          drop_o,
  output logic [AW-1:0] wr_idx_o,
  output logic [AW-1:0] rd_idx_o,
  output logic [AW:0]   level_o
);

  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic        full, empty;

  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = ptr_full(PtrMaxW'(rd_ptr_q), PtrMaxW'(wr_ptr_q), AW);

  always_comb begin
    rd_en_o  = !stall_i && !empty;
    wr_en_o  = wr_req_i && (!full || rd_en_o);
    drop_o   = wr_req_i && !wr_en_o;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (rd_en_o) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en_o) wr_ptr_d = wr_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign wr_idx_o = wr_ptr_q[AW-1:0];
  assign rd_idx_o = rd_ptr_q[AW-1:0];
  assign level_o  = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fifo_encoder.sv
// Collapses each two-cycle repeated input symbol into one FIFO entry,
// flags mismatched pairs and dropped pairs, and drains one word per cycle.
module fifo_encoder
  import fifo_codec_pkg::*;
#(
  parameter int unsigned DW     = DefDw,
  parameter int unsigned LENGTH = DefLength,
  parameter int unsigned AW     = $clog2(LENGTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic [DW-1:0] DIN,
  input  logic          STALL,
  output logic [DW-1:0] DOUT,
  output logic          DOUT_VALID,
  output logic [AW:0]   LEVEL,
  output logic          PAIR_ERR,
  output logic          OVF
);

  logic          phase_q, phase_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          pair_err_q, pair_err_d;
  logic          ovf_q, ovf_d;
  logic          pair_done;
  logic          wr_en, rd_en, drop;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [DW-1:0] mem [LENGTH];

  assign pair_done = EN && phase_q;

  fifo_ptr_ctl #(
    .LENGTH (LENGTH),
    .AW     (AW)
  ) u_ptr_ctl (
    .clk_i    (CLK),
    .rst_i    (RST),
    .wr_req_i (pair_done),
    .stall_i  (STALL),
    .wr_en_o  (wr_en),
    .rd_en_o  (rd_en),
    .drop_o   (drop),
    .wr_idx_o (wr_idx),
    .rd_idx_o (rd_idx),
    .level_o  (LEVEL)
  );

  always_comb begin
    // A gap in EN abandons any half-received pair.
    phase_d      = EN ? !phase_q : 1'b0;
    hold_d       = (EN && !phase_q) ? DIN : hold_q;
    pair_err_d   = pair_done && (DIN != hold_q);
    ovf_d        = drop;
    dout_valid_d = rd_en;
    dout_d       = rd_en ? mem[rd_idx] : dout_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q      <= 1'b0;
      hold_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      pair_err_q   <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      hold_q       <= hold_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      pair_err_q   <= pair_err_d;
      ovf_q        <= ovf_d;
    end
  end

  // Storage is not reset; the pointers alone define valid contents.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en) mem[wr_idx] <= hold_q;
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign PAIR_ERR   = pair_err_q;
  assign OVF        = ovf_q;

endmodule

// File: tb/tb_fifo_encoder.sv
// Scoreboard bench for fifo_encoder: stimulus queues expected words,
// a negedge monitor pops and compares every DOUT_VALID word.
module tb_fifo_encoder;
  import fifo_codec_pkg::*;

  logic       CLK = 1'b0;
  logic       RST, EN, STALL;
  logic [3:0] DIN;
  logic [3:0] DOUT;
  logic       DOUT_VALID, PAIR_ERR, OVF;
  logic [2:0] LEVEL;

  int   checks = 0;
  int   errors = 0;
  int   perr_cnt = 0;
  int   ovf_cnt = 0;
  sym_t sb[$];

  fifo_encoder #(
    .DW     (4),
    .LENGTH (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .DIN        (DIN),
    .STALL      (STALL),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .LEVEL      (LEVEL),
    .PAIR_ERR   (PAIR_ERR),
    .OVF        (OVF)
  );

  always #5 CLK = ~CLK;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      if (PAIR_ERR) perr_cnt++;
      if (OVF) ovf_cnt++;
      if (DOUT_VALID) begin
        if (sb.size() == 0) begin
          check("unexpected_dout", 1, 0);
        end else begin
          check("dout_data", int'(DOUT), int'(sb.pop_front()));
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Presents a and b on two consecutive cycles with EN=1; returns in the
  // cycle after the repeat copy, EN left high.
  task automatic pair(input logic [3:0] a, input logic [3:0] b);
    EN  = 1'b1;
    DIN = a;
    step();
    DIN = b;
    step();
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; STALL = 1'b0; DIN = '0;
    step(2);
    RST = 1'b0;
    check("rst_dout", int'(DOUT), 0);
    check("rst_valid", int'(DOUT_VALID), 0);
    check("rst_level", int'(LEVEL), 0);
    check("rst_perr", int'(PAIR_ERR), 0);
    check("rst_ovf", int'(OVF), 0);

    // Streaming 3,3,5,5,9,9 with latency check on the first word.
    sb.push_back(4'd3); sb.push_back(4'd5); sb.push_back(4'd9);
    EN = 1'b1; DIN = 4'd3; step();
    DIN = 4'd3; step();
    DIN = 4'd5; step();
    check("lat_valid", int'(DOUT_VALID), 1);
    check("lat_data", int'(DOUT), 3);
    DIN = 4'd5; step();
    pair(4'd9, 4'd9);
    EN = 1'b0; step(5);
    check("stream_level", int'(LEVEL), 0);
    check("stream_perr", perr_cnt, 0);
    check("stream_ovf", ovf_cnt, 0);

    // Mismatched pair: first copy is stored, error pulses once.
    sb.push_back(4'd6);
    pair(4'd6, 4'd7);
    EN = 1'b0;
    check("perr_pulse", int'(PAIR_ERR), 1);
    step();
    check("perr_clear", int'(PAIR_ERR), 0);
    step(4);
    check("perr_cnt", perr_cnt, 1);

    // Fill under stall, overflow on the fifth pair.
    STALL = 1'b1;
    sb.push_back(4'hA); sb.push_back(4'hB); sb.push_back(4'hC); sb.push_back(4'hD);
    pair(4'hA, 4'hA);
    pair(4'hB, 4'hB);
    pair(4'hC, 4'hC);
    pair(4'hD, 4'hD);
    check("full_level", int'(LEVEL), 4);
    pair(4'hE, 4'hE);
    EN = 1'b0;
    check("ovf_pulse", int'(OVF), 1);
    check("ovf_level", int'(LEVEL), 4);
    step();
    check("ovf_clear", int'(OVF), 0);

    // Full with simultaneous read: write accepted, occupancy unchanged.
    sb.push_back(4'hF);
    EN = 1'b1; DIN = 4'hF; step();
    STALL = 1'b0; step();
    EN = 1'b0;
    check("simul_level", int'(LEVEL), 4);
    check("simul_ovf", int'(OVF), 0);
    step(8);
    check("drain_level", int'(LEVEL), 0);
    check("ovf_cnt", ovf_cnt, 1);

    // Interrupted pair is abandoned and phase realigns.
    sb.push_back(4'd4);
    EN = 1'b1; DIN = 4'd2; step();
    EN = 1'b0; step();
    pair(4'd4, 4'd4);
    EN = 1'b0;
    step(4);
    check("abandon_level", int'(LEVEL), 0);
    check("abandon_perr", perr_cnt, 1);

    // Reset with stored entries and a pending first copy.
    STALL = 1'b1;
    pair(4'd7, 4'd7);
    pair(4'd8, 4'd8);
    pair(4'd9, 4'd9);
    DIN = 4'd5; step();
    check("pre_rst_level", int'(LEVEL), 3);
    RST = 1'b1; EN = 1'b0; STALL = 1'b0; step();
    RST = 1'b0;
    check("mid_rst_level", int'(LEVEL), 0);
    check("mid_rst_valid", int'(DOUT_VALID), 0);
    check("mid_rst_dout", int'(DOUT), 0);

    sb.push_back(4'd1);
    EN = 1'b1; DIN = 4'd1; step();
    DIN = 4'd1; step();
    EN = 1'b0; step();
    check("post_rst_valid", int'(DOUT_VALID), 1);
    check("post_rst_data", int'(DOUT), 1);
    step(4);
    check("sb_empty", sb.size(), 0);
    check("final_perr", perr_cnt, 1);
    check("final_ovf", ovf_cnt, 1);
    check("final_level", int'(LEVEL), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
